// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with programmable wait
// states, byte/half/word lane steering and load sign/zero extension.
// Optional build macro: MEM_RESP_MISALIGN_ERR_EN -- when defined, misaligned
// half/word accesses fault; otherwise the low address bits are ignored.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(64'(DEPTH_WORDS) * 64'd4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              accept, enter_resp;

  logic              lat_we, lat_unsigned;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_size;
  logic [31:0]       lat_wdata;

  logic              a_we, a_unsigned;
  logic [ADDR_W-1:0] a_addr;
  logic [1:0]        a_size;
  logic [31:0]       a_wdata;

  logic [IDX_W-1:0]  idx;
  logic              size_err, range_err, mis_err, acc_err;
  logic [3:0]        be;
  logic [31:0]       wlane, rword, byte_shift, half_shift, load_val, rdata_next;

  logic [31:0]       mem [DEPTH_WORDS];

  // State register and wait-state counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          cnt_next = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        busy     = 1'b1;
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the request on the accept edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_wdata    <= '0;
    end else if (accept) begin
      lat_we       <= req_we;
      lat_addr     <= req_addr;
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_wdata    <= req_wdata;
    end
  end

  // Access decode; with zero latency the array is touched on the accept edge,
  // so in IDLE the live request drives the access instead of the latched copy.
  always_comb begin
    a_we       = (state == IDLE) ? req_we       : lat_we;
    a_addr     = (state == IDLE) ? req_addr     : lat_addr;
    a_size     = (state == IDLE) ? req_size     : lat_size;
    a_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
    a_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;

    idx       = a_addr[IDX_W+1:2];
    size_err  = (a_size == 2'b11);
    range_err = ({1'b0, a_addr} >= LIMIT);
`ifdef MEM_RESP_MISALIGN_ERR_EN
    mis_err   = ((a_size == 2'b01) && a_addr[0]) ||
                ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
`else
    mis_err   = 1'b0;
`endif
    acc_err   = size_err | range_err | mis_err;

    case (a_size)
      2'b00: begin
        be    = 4'b0001 << a_addr[1:0];
        wlane = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be    = a_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{a_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = a_wdata;
      end
    endcase

    rword      = mem[idx];
    byte_shift = rword >> {a_addr[1:0], 3'b000};
    half_shift = rword >> {a_addr[1], 4'b0000};
    case (a_size)
      2'b00:   load_val = a_unsigned ? {24'd0, byte_shift[7:0]}
                                     : {{24{byte_shift[7]}}, byte_shift[7:0]};
      2'b01:   load_val = a_unsigned ? {16'd0, half_shift[15:0]}
                                     : {{16{half_shift[15]}}, half_shift[15:0]};
      default: load_val = rword;
    endcase
    rdata_next = (a_we || acc_err) ? '0 : load_val;
  end

  // Backing array: lane-masked store commits on the edge entering RESP
  always_ff @(posedge clk) begin
    if (enter_resp && a_we && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  // Response registers, held stable through backpressure
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_rdata <= rdata_next;
      resp_err   <= acc_err;
    end
  end

endmodule
